// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// elaboration-time clog2 used to size the bit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder; the single datapath cell of serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one
// full_adder, giving {cout,sum} = a + b + cin after WIDTH shift cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW_RAW = clog2(WIDTH + 1);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, a_sh_next;
  logic [WIDTH-1:0] b_sh_reg, b_sh_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [WIDTH-1:0] s_shifted;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             fa_s, fa_cout;

  full_adder u_fa (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // The partial-sum register keeps only the upper WIDTH-1 bits: on the final
  // shift the lowest bit goes straight from s_shifted into sum_reg.
  generate
    if (WIDTH == 1) begin : g_one
      assign s_shifted = fa_s;
    end else begin : g_multi
      logic [WIDTH-1:1] s_sh_reg;
      genvar gi;
      for (gi = 1; gi < WIDTH; gi++) begin : g_sh
        assign s_shifted[gi-1] = s_sh_reg[gi];
      end
      assign s_shifted[WIDTH-1] = fa_s;

      always_ff @(posedge clk) begin
        if (rst) begin
          s_sh_reg <= '0;
        end else if (state_reg == ST_SHIFT) begin
          s_sh_reg <= s_shifted[WIDTH-1:1];
        end else if (start) begin
          s_sh_reg <= '0;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    a_sh_next  = a_sh_reg;
    b_sh_next  = b_sh_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_SHIFT;
          a_sh_next  = a;
          b_sh_next  = b;
          carry_next = cin;
          cnt_next   = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_sh_next  = a_sh_reg >> 1;
        b_sh_next  = b_sh_reg >> 1;
        carry_next = fa_cout;
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = ST_DONE;
          sum_next   = s_shifted;
          cout_next  = fa_cout;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_sh_reg  <= a_sh_next;
      b_sh_reg  <= b_sh_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
    end
  end

  assign busy = (state_reg == ST_SHIFT);
  assign done = (state_reg == ST_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
